// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low glyphs (bit 6 = a ... bit 0 = g),
// the blank pattern and the 4-digit frame type used by the display arbiter.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h01;
  localparam logic [6:0] SEG_1 = 7'h4F;
  localparam logic [6:0] SEG_2 = 7'h12;
  localparam logic [6:0] SEG_3 = 7'h06;
  localparam logic [6:0] SEG_4 = 7'h4C;
  localparam logic [6:0] SEG_5 = 7'h24;
  localparam logic [6:0] SEG_6 = 7'h20;
  localparam logic [6:0] SEG_7 = 7'h0F;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h04;

  // Letters used by status/alert messages ("Err", "HELP", "----").
  localparam logic [6:0] SEG_E    = 7'h30;
  localparam logic [6:0] SEG_R    = 7'h7A;
  localparam logic [6:0] SEG_H    = 7'h48;
  localparam logic [6:0] SEG_L    = 7'h71;
  localparam logic [6:0] SEG_P    = 7'h18;
  localparam logic [6:0] SEG_DASH = 7'h7E;

  // Element [3] is the leftmost digit, so a frame aligns with a 28-bit seg_in slice.
  typedef logic [3:0][6:0] frame_t;

  localparam frame_t FRAME_BLANK = {4{SEG_BLANK}};

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = SEG_0;
      4'd1:    seg_digit = SEG_1;
      4'd2:    seg_digit = SEG_2;
      4'd3:    seg_digit = SEG_3;
      4'd4:    seg_digit = SEG_4;
      4'd5:    seg_digit = SEG_5;
      4'd6:    seg_digit = SEG_6;
      4'd7:    seg_digit = SEG_7;
      4'd8:    seg_digit = SEG_8;
      4'd9:    seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ssd_rr_pick.sv
// Combinational round-robin picker: first requester at or after `start` (with
// wrap) that is not masked by `excl`.
module ssd_rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic          valid
);

  logic [N-1:0]  cand;
  int            idx_i;
  logic [IW-1:0] idx;

  always_comb begin
    cand  = req & ~excl;
    win   = '0;
    valid = 1'b0;
    idx_i = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx_i = (int'(start) + k) % N;
      idx   = idx_i[IW-1:0];
      if (!valid && cand[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_share_arbiter.sv
// Time-shares the 4-digit display between NCLI clients: round-robin grants with a
// guaranteed minimum of HOLD cycles on screen, registered digit outputs.
module ssd_share_arbiter
  import ssd_pkg::*;
#(
  parameter int NCLI = 3,
  parameter int HOLD = 50_000_000,
  parameter int CW   = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCLI-1:0]    req,
  input  logic [28*NCLI-1:0] seg_in,
  output logic [NCLI-1:0]    gnt,
  output logic [NCLI-1:0]    done,
  output logic               busy,
  output logic [6:0]         SSD3,
  output logic [6:0]         SSD2,
  output logic [6:0]         SSD1,
  output logic [6:0]         SSD0
);

  localparam int            IW       = $clog2(NCLI);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
  localparam logic [IW-1:0] PTR_LAST = IW'(NCLI - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  // req/gnt handshake: req is a level held by the client for as long as it wants
  // the screen; gnt is one-hot and registered, and a grant ends only with a
  // one-cycle done pulse (or reset). A client may drop req at any time.
  state_t          state, state_n;
  logic [NCLI-1:0] gnt_n, done_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   ptr, ptr_n;
  frame_t          frame, frame_n;

  logic [IW-1:0]   start;
  logic [NCLI-1:0] excl, win;
  logic            win_valid;
  logic [IW-1:0]   win_idx;
  frame_t          cli_frame [NCLI];

  for (genvar i = 0; i < NCLI; i++) begin : g_frames
    assign cli_frame[i] = seg_in[28*i +: 28];
  end

  // In SHOW ptr equals the granted client, so one picker serves both cases.
  assign start = (ptr == PTR_LAST) ? '0 : ptr + IW'(1);
  assign excl  = (state == SHOW) ? gnt : '0;

  ssd_rr_pick #(.N(NCLI), .IW(IW)) u_pick (
    .req   (req),
    .start (start),
    .excl  (excl),
    .win   (win),
    .valid (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (win[i]) win_idx = IW'(i);
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = '0;
    cnt_n   = cnt;
    ptr_n   = ptr;
    frame_n = frame;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_n = SHOW;
          gnt_n   = win;
          cnt_n   = CNT_LOAD;
          ptr_n   = win_idx;
          frame_n = cli_frame[win_idx];
        end else begin
          frame_n = FRAME_BLANK;
        end
      end
      SHOW: begin
        if (|(req & gnt)) frame_n = cli_frame[ptr];
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (win_valid) begin
          done_n  = gnt;
          gnt_n   = win;
          cnt_n   = CNT_LOAD;
          ptr_n   = win_idx;
          frame_n = cli_frame[win_idx];
        end else if (!(|(req & gnt))) begin
          done_n  = gnt;
          gnt_n   = '0;
          state_n = IDLE;
          frame_n = FRAME_BLANK;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      cnt   <= '0;
      ptr   <= PTR_LAST;
      frame <= FRAME_BLANK;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      frame <= frame_n;
    end
  end

  assign busy = (state == SHOW);
  assign SSD3 = frame[3];
  assign SSD2 = frame[2];
  assign SSD1 = frame[1];
  assign SSD0 = frame[0];

endmodule

// File: tb/tb_ssd_share_arbiter.sv
// Bench for ssd_share_arbiter (NCLI=3, HOLD=4): directed scenarios plus random
// traffic, every cycle compared against a time-on-screen reference model.
module tb_ssd_share_arbiter;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam logic [27:0] BLANK28 = {4{7'h7F}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [28*N-1:0] seg_in = '0;
  logic [N-1:0]  gnt, done;
  logic          busy;
  logic [6:0]    SSD3, SSD2, SSD1, SSD0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the screen, for how many cycles, who won last.
  int          m_owner;
  int          m_shown;
  int          m_last;
  logic [27:0] m_ssd;
  logic [N-1:0] m_done;

  ssd_share_arbiter #(.NCLI(N), .HOLD(HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .seg_in (seg_in),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .SSD3   (SSD3),
    .SSD2   (SSD2),
    .SSD1   (SSD1),
    .SSD0   (SSD0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_next(input logic [N-1:0] r, input int from, input int skip);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (from + k) % N;
      if (c != skip && r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [27:0] client_seg(input int c);
    return seg_in[28*c +: 28];
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_shown = 0;
    m_last  = N - 1;
    m_ssd   = BLANK28;
    m_done  = '0;
  endtask

  task automatic model_step();
    int w;
    m_done = '0;
    if (m_owner < 0) begin
      w = find_next(req, m_last, -1);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_shown = 1; m_ssd = client_seg(w);
      end else begin
        m_ssd = BLANK28;
      end
    end else begin
      w = (m_shown >= HOLD) ? find_next(req, m_owner, m_owner) : -1;
      if (w >= 0) begin
        m_done[m_owner] = 1'b1;
        m_owner = w; m_last = w; m_shown = 1; m_ssd = client_seg(w);
      end else if (m_shown >= HOLD && !req[m_owner]) begin
        m_done[m_owner] = 1'b1;
        m_owner = -1; m_shown = 0; m_ssd = BLANK28;
      end else begin
        m_shown++;
        if (req[m_owner]) m_ssd = client_seg(m_owner);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? '0 : N'(1 << m_owner);
    check({tag, ".gnt"},  32'(gnt),  32'(exp_gnt));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    check({tag, ".ssd"},  32'({SSD3, SSD2, SSD1, SSD0}), 32'(m_ssd));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic reset_now(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".raw"}, 32'({gnt, done, busy, SSD0}), 32'({3'b000, 3'b000, 1'b0, 7'h7F}));
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [95:0] rnd;
    model_reset();
    @(negedge clk);
    reset_now("reset");

    // Single client, request dropped after one cycle: frozen, held, then blank.
    seg_in[27:0] = 28'h0000001;
    req = 3'b001;
    cycle("single.grant");
    check("single.gnt0", 32'(gnt), 32'(3'b001));
    check("single.ssd0", 32'(SSD0), 32'(7'h01));
    req = 3'b000;
    seg_in[27:0] = 28'h1234567;
    for (int i = 0; i < 3; i++) cycle("single.hold");
    check("single.frozen", 32'(SSD0), 32'(7'h01));
    cycle("single.end");
    check("single.done", 32'({done, gnt}), 32'({3'b001, 3'b000}));
    cycle("single.idle");

    // All three request from reset: 001,010,100,001... every 4 cycles, no gaps.
    reset_now("rr.reset");
    rnd = {$urandom(), $urandom(), $urandom()};
    seg_in = rnd[28*N-1:0];
    req = 3'b111;
    for (int i = 1; i <= 16; i++) begin
      cycle("rr");
      check("rr.order", 32'(gnt), 32'(1 << (((i - 1) / HOLD) % N)));
    end
    // Mid-SHOW asynchronous reset.
    #3;
    reset_now("reset.mid");

    // Sole requester stays past HOLD, then yields to a newcomer at once.
    req = 3'b010;
    for (int i = 0; i < 20; i++) begin
      cycle("sole");
      check("sole.gnt", 32'(gnt), 32'(3'b010));
    end
    req = 3'b110;
    cycle("sole.handover");
    check("sole.switch", 32'({done, gnt}), 32'({3'b010, 3'b100}));

    // Live digit update with one-cycle latency.
    reset_now("live.reset");
    seg_in[27:0] = {7'h12, 7'h06, 7'h4F, 7'h40};
    req = 3'b001;
    for (int i = 0; i < 3; i++) cycle("live");
    check("live.before", 32'(SSD0), 32'(7'h40));
    seg_in[6:0] = 7'h79;
    cycle("live.after");
    check("live.ssd0", 32'(SSD0), 32'(7'h79));

    // Handover at expiry must skip the current holder.
    reset_now("excl.reset");
    req = 3'b100;
    cycle("excl.grant2");
    req = 3'b101;
    for (int i = 0; i < 3; i++) cycle("excl.hold");
    cycle("excl.switch");
    check("excl.gnt", 32'({done, gnt}), 32'({3'b100, 3'b001}));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
      rnd = {$urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) seg_in = rnd[28*N-1:0];
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_share_arbiter.md
# ssd_share_arbiter

Time-shares the 4-digit seven-segment display driver between several requesters (score readout, status messages, alerts). Round-robin arbitration with a guaranteed minimum on-screen time per grant. The block registers the winning client's four 7-bit digit patterns onto `SSD3`..`SSD0`, which feed the display scanner directly. Sits between the game or control logic and the display driver, and is the only writer of the driver's digit inputs.

## Interface
Parameters:
- `NCLI`, 3: number of requesting clients; must be ≥ 2.
- `HOLD`, 50_000_000: minimum cycles a granted client stays on screen; must be ≥ 1.
- `CW`, $clog2(HOLD): width of the hold counter (derived).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NCLI: level request per client; bit i = client i.
- `seg_in` in 28*NCLI: digit patterns per client. Bits [28i+27:28i+21] = digit3 … [28i+6:28i] = digit0. Each pattern is a..g, MSB=a, active-low.
- `gnt` out NCLI: one-hot grant, registered; all-zero when idle.
- `done` out NCLI: one-cycle pulse on client i when its grant ends.
- `busy` out 1: high while any grant is held.
- `SSD3`, `SSD2`, `SSD1`, `SSD0` out 7 each: registered digit patterns to the display driver.

## Operation
- States: IDLE and SHOW.
- Reset values:
  - State IDLE.
  - `gnt`=0, `done`=0, `busy`=0.
  - `SSD3`..`SSD0`=7'h7F (all segments off).
  - Hold counter = 0.
  - RR pointer = NCLI-1, so client 0 wins first.
- IDLE, with any `req` set:
  - Pick the winner w by round-robin, searching upward from pointer+1 with wrap.
  - Set `gnt`=1<<w, counter=HOLD-1, pointer=w.
  - Load `SSD*` from `seg_in` of client w.
  - Go to SHOW.
- IDLE, with no `req`: `SSD*` = 7'h7F.
- SHOW, granted client g:
  - If `req[g]`=1, `SSD*` reload from client g every cycle (live update).
  - If `req[g]`=0, `SSD*` hold their last value (frozen) until the grant ends.
  - Counter decrements each cycle until it reaches 0, then stays at 0.
- Grant end, evaluated only when counter==0:
  - **Another request pending:** pulse `done[g]`. Re-arbitrate among all requesters except g, searching from g+1. Switch `gnt` to the new winner and reload the counter on the same edge; there is no blank cycle between grants.
  - **No other request, `req[g]`=1:** keep the grant. Counter stays 0. This condition is re-evaluated every cycle.
  - **No other request, `req[g]`=0:** pulse `done[g]`, clear `gnt`, go to IDLE, blank `SSD*`.
- `busy` equals (state==SHOW).
- Reset asserted mid-SHOW: outputs return to reset values immediately. No `done` pulse is issued.

## Timing
- Request-to-grant latency: `req` sampled high at edge t in IDLE gives `gnt` and `SSD*` valid after edge t.
- `SSD*` track live `seg_in` with 1-cycle latency while the grant is held.
- A grant lasts at least HOLD cycles of `gnt` high.
- When a grant ends:
  - `done[g]` is high for exactly the one cycle that follows the ending edge.
  - On a handover, that same cycle also shows the new `gnt`.
- With HOLD=1 the counter loads 0, so a handover can occur on the next edge.
- All outputs are registered. There is no combinational path from `req` or `seg_in` to any output.

## Structure
- Shared package `ssd_pkg` holds:
  - `SEG_BLANK` = 7'h7F.
  - Active-low glyph constants for 0–9 and the letters used by messages.
  - A typedef for a 4-digit frame (4×7 bits).
- Sub-module `ssd_rr_pick`: a combinational round-robin picker. Inputs: request vector, start index, exclude mask. Outputs: one-hot winner and a valid flag. It is instantiated once.
- The FSM, hold counter and output registers live in the top module.

## Test plan
All directed tests use NCLI=3 and HOLD=4.
1. **Reset:** assert `rst` mid-SHOW → `gnt`=000, `busy`=0, all `SSD*`=7'h7F in the same cycle; no `done` pulse.
2. **Single client:** `req`=001 with `seg_in[27:0]`=28'h0000001 → `gnt`=001 one cycle later and `SSD0`=7'h01. Drop `req` after 1 cycle → `SSD*` frozen, `gnt` held 4 cycles total, then `done`=001 for one cycle, then blank.
3. **Simultaneous requests from reset:** `req`=111 → grant order 001, 010, 100, 001 … Each grant lasts exactly 4 cycles. `done` pulses coincide with each switch, with no blank cycle between grants.
4. **Sole requester past HOLD:** client 1 keeps `req` high for 20 cycles with no competitors → `gnt`=010 for all 20 cycles. Client 2 then requests → switch to 100 on the next edge and `done`=010.
5. **Live update:** client 0 is granted and its digit0 changes 7'h40→7'h79 at cycle k → `SSD0`=7'h79 from cycle k+1.
6. **Exclusion on handover:** client 2 is granted and both 0 and 2 are requesting at expiry → the new grant is 001, never a re-grant to 2.
